// File: rtl/cn_msg_gen.sv
// -----------------------------------------------------------------------------
// cn_msg_gen
//
// Check-node message generator for a min-sum LDPC decoder. One compressed
// check-node record is accepted per handshake:
//   min / second-min magnitude, the index of the edge that holds the minimum,
//   the product (XOR) of all edge signs and the per-edge input sign vector.
// The block then emits DEG outgoing messages, one per edge, in edge order
// 0..DEG-1. Each edge gets the smallest magnitude of the *other* edges
// (submin on the min edge, min elsewhere), less an offset-min-sum correction
// saturated at zero. Its sign is the total sign product with the edge's own
// sign removed.
//
// Parameters
//   WIDTH  : magnitude width
//   DEG    : check-node degree (messages per record)
//   IDXW   : edge index width
//   OFFSET : correction subtracted from every outgoing magnitude
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   cmp_valid / cmp_ready         : compressed record handshake
//   min_v, submin_v, min_idx,
//   sign_prod, sign_vec           : compressed record fields
//   msg_valid / msg_ready         : outgoing message handshake
//   msg_mag, msg_sign, msg_idx,
//   msg_last                      : outgoing message (all zero while idle)
// -----------------------------------------------------------------------------
module cn_msg_gen #(
    parameter int WIDTH  = 7,
    parameter int DEG    = 24,
    parameter int IDXW   = 5,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    // compressed record input
    input  logic             cmp_valid,
    output logic             cmp_ready,
    input  logic [WIDTH-1:0] min_v,
    input  logic [WIDTH-1:0] submin_v,
    input  logic [IDXW-1:0]  min_idx,
    input  logic             sign_prod,
    input  logic [DEG-1:0]   sign_vec,
    // outgoing message stream
    output logic             msg_valid,
    input  logic             msg_ready,
    output logic [WIDTH-1:0] msg_mag,
    output logic             msg_sign,
    output logic [IDXW-1:0]  msg_idx,
    output logic             msg_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEG - 1);

    // An offset at or beyond 2**WIDTH zeroes every magnitude; clamping keeps
    // the comparison constant representable in WIDTH+1 bits.
    localparam int              OFF_CLAMP  = (OFFSET > (1 << WIDTH)) ? (1 << WIDTH) : OFFSET;
    localparam logic [WIDTH:0]  OFF_EXT    = (WIDTH + 1)'(OFF_CLAMP);
    // Only used when raw >= OFFSET, in which case OFFSET fits in WIDTH bits.
    localparam logic [WIDTH-1:0] OFF_NARROW = WIDTH'(OFF_CLAMP);

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   cnt_reg, cnt_next;
    logic              load;

    // registered record
    logic [WIDTH-1:0]  min_reg;
    logic [WIDTH-1:0]  submin_reg;
    logic [IDXW-1:0]   min_idx_reg;
    logic              sign_prod_reg;
    logic [DEG-1:0]    sign_vec_reg;

    // datapath
    logic [DEG-1:0]    edge_sel;
    logic [DEG-1:0]    edge_sign;
    logic [WIDTH-1:0]  raw_mag;
    logic [WIDTH-1:0]  sat_mag;
    logic              emit;

    // -------------------------------------------------------------------------
    // Control FSM: state and edge counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cmp_ready  = 1'b0;
        msg_valid  = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                cmp_ready = 1'b1;
                if (cmp_valid) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                msg_valid = 1'b1;
                if (msg_ready) begin
                    if (cnt_reg == LAST_IDX) begin
                        // Returning to IDLE costs one bubble cycle before
                        // the next record can be taken.
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Record registers: loaded only on the input handshake, so input activity
    // during EMIT cannot disturb the record being emitted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            min_reg       <= '0;
            submin_reg    <= '0;
            min_idx_reg   <= '0;
            sign_prod_reg <= 1'b0;
            sign_vec_reg  <= '0;
        end else if (load) begin
            min_reg       <= min_v;
            submin_reg    <= submin_v;
            min_idx_reg   <= min_idx;
            sign_prod_reg <= sign_prod;
            sign_vec_reg  <= sign_vec;
        end
    end

    // -------------------------------------------------------------------------
    // Per-edge sign selection: one-hot decode of the counter masks the input
    // sign vector, so the current edge's own sign is a simple OR-reduction.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEG; gi++) begin : g_edge
            assign edge_sel[gi]  = (cnt_reg == IDXW'(gi));
            assign edge_sign[gi] = edge_sel[gi] & sign_vec_reg[gi];
        end
    endgenerate

    // The min edge sees the second minimum; every other edge sees the minimum.
    // A min_idx outside 0..DEG-1 never matches, so all edges get min.
    assign raw_mag = (cnt_reg == min_idx_reg) ? submin_reg : min_reg;

    // Offset correction, clamped at zero instead of wrapping.
    assign sat_mag = ({1'b0, raw_mag} >= OFF_EXT) ? (raw_mag - OFF_NARROW) : '0;

    assign emit = (state_reg == EMIT);

    // Outputs derive only from registered state, so they hold through stalls
    // and read as zero while idle.
    assign msg_mag  = emit ? sat_mag : '0;
    assign msg_sign = emit & (sign_prod_reg ^ (|edge_sign));
    assign msg_idx  = emit ? cnt_reg : '0;
    assign msg_last = emit & (cnt_reg == LAST_IDX);

endmodule

// File: tb/tb_cn_msg_gen.sv
// -----------------------------------------------------------------------------
// tb_cn_msg_gen
//
// Directed bench for cn_msg_gen. Two instances share every input: one with
// OFFSET=0 and one with OFFSET=2, so the offset path is exercised alongside
// the plain path. Inputs are driven 1 ns after a rising edge and outputs are
// sampled at the same point, i.e. they show the state settled by that edge.
// -----------------------------------------------------------------------------
module tb_cn_msg_gen;

    localparam int DEG = 24;

    logic        clk;
    logic        rst;
    logic        cmp_valid;
    logic [6:0]  min_v;
    logic [6:0]  submin_v;
    logic [4:0]  min_idx;
    logic        sign_prod;
    logic [23:0] sign_vec;
    logic        msg_ready;

    logic        cmp_ready, msg_valid, msg_sign, msg_last;
    logic [6:0]  msg_mag;
    logic [4:0]  msg_idx;

    logic        cmp_ready_o2, msg_valid_o2, msg_sign_o2, msg_last_o2;
    logic [6:0]  msg_mag_o2;
    logic [4:0]  msg_idx_o2;

    int tests = 0;
    int fails = 0;

    // collected messages
    logic [6:0] got_mag  [DEG];
    logic [6:0] got_mag2 [DEG];
    logic       got_sign [DEG];
    logic [4:0] got_idx  [DEG];
    logic       got_last [DEG];
    int         n_got;
    int         stall_bad;
    int         cycles;
    bit         timed_out;

    cn_msg_gen #(.WIDTH(7), .DEG(24), .IDXW(5), .OFFSET(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmp_valid (cmp_valid),
        .cmp_ready (cmp_ready),
        .min_v     (min_v),
        .submin_v  (submin_v),
        .min_idx   (min_idx),
        .sign_prod (sign_prod),
        .sign_vec  (sign_vec),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_mag   (msg_mag),
        .msg_sign  (msg_sign),
        .msg_idx   (msg_idx),
        .msg_last  (msg_last)
    );

    cn_msg_gen #(.WIDTH(7), .DEG(24), .IDXW(5), .OFFSET(2)) dut_off (
        .clk       (clk),
        .rst       (rst),
        .cmp_valid (cmp_valid),
        .cmp_ready (cmp_ready_o2),
        .min_v     (min_v),
        .submin_v  (submin_v),
        .min_idx   (min_idx),
        .sign_prod (sign_prod),
        .sign_vec  (sign_vec),
        .msg_valid (msg_valid_o2),
        .msg_ready (msg_ready),
        .msg_mag   (msg_mag_o2),
        .msg_sign  (msg_sign_o2),
        .msg_idx   (msg_idx_o2),
        .msg_last  (msg_last_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a record and clock it in; optionally keep cmp_valid asserted.
    task automatic send(input logic [6:0] mn, input logic [6:0] sm, input logic [4:0] id,
                        input logic sp, input logic [23:0] sv, input bit hold);
        min_v     = mn;
        submin_v  = sm;
        min_idx   = id;
        sign_prod = sp;
        sign_vec  = sv;
        cmp_valid = 1'b1;
        tick();
        if (!hold) cmp_valid = 1'b0;
    endtask

    // Drain one record. mode 0: msg_ready always high; mode 1: random stalls.
    // Records every handshaked message and counts output changes during stalls.
    task automatic collect(input int mode);
        logic [14:0] prev_vec;
        bit          prev_hold;
        prev_hold = 1'b0;
        prev_vec  = '0;
        n_got     = 0;
        stall_bad = 0;
        cycles    = 0;
        timed_out = 1'b0;
        while (n_got < DEG && cycles < 400) begin
            if (prev_hold && {msg_valid, msg_mag, msg_sign, msg_idx, msg_last} !== prev_vec)
                stall_bad++;
            msg_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (msg_valid && msg_ready) begin
                got_mag[n_got]  = msg_mag;
                got_mag2[n_got] = msg_mag_o2;
                got_sign[n_got] = msg_sign;
                got_idx[n_got]  = msg_idx;
                got_last[n_got] = msg_last;
                n_got++;
            end
            prev_hold = msg_valid && !msg_ready;
            prev_vec  = {msg_valid, msg_mag, msg_sign, msg_idx, msg_last};
            cycles++;
            tick();
        end
        msg_ready = 1'b1;
        if (n_got < DEG) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (cmp_ready !== 1'b1) begin
            fails++; $display("FAIL reset_cmp_ready: got %0b expected 1", cmp_ready);
        end
        tests++;
        if (msg_valid !== 1'b0) begin
            fails++; $display("FAIL reset_msg_valid: got %0b expected 0", msg_valid);
        end
        tests++;
        if ({msg_mag, msg_sign, msg_idx, msg_last} !== 14'd0) begin
            fails++; $display("FAIL reset_msg_outputs: mag=%0d sign=%0b idx=%0d last=%0b expected all 0",
                              msg_mag, msg_sign, msg_idx, msg_last);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        send(7'd3, 7'd9, 5'd5, 1'b1, 24'h000000, 1'b0);
        tests++;
        if (msg_valid !== 1'b1 || msg_idx !== 5'd0) begin
            fails++; $display("FAIL basic_latency: msg_valid=%0b idx=%0d expected 1/0", msg_valid, msg_idx);
        end
        collect(0);
        tests++;
        if (timed_out || cycles != DEG) begin
            fails++; $display("FAIL basic_count: got %0d msgs in %0d cycles expected %0d in %0d", n_got, cycles, DEG, DEG);
        end
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_idx[i] !== 5'(i) || got_mag[i] !== ((i == 5) ? 7'd9 : 7'd3) ||
                got_sign[i] !== 1'b1 || got_last[i] !== (i == DEG - 1)) begin
                fails++; $display("FAIL basic_msg%0d: idx=%0d mag=%0d sign=%0b last=%0b expected idx=%0d mag=%0d sign=1 last=%0b",
                                  i, got_idx[i], got_mag[i], got_sign[i], got_last[i], i, (i == 5) ? 9 : 3, i == DEG - 1);
            end
        end
        tests++;
        if (cmp_ready !== 1'b1 || msg_valid !== 1'b0 || msg_mag !== 7'd0) begin
            fails++; $display("FAIL basic_return_idle: cmp_ready=%0b msg_valid=%0b mag=%0d expected 1/0/0",
                              cmp_ready, msg_valid, msg_mag);
        end
        $display("[TB] test_basic done: %0d messages", n_got);
    endtask

    task automatic test_offset();
        send(7'd1, 7'd4, 5'd0, 1'b0, 24'h000000, 1'b0);
        collect(0);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL offset_count: got %0d msgs expected %0d", n_got, DEG);
        end
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_mag2[i] !== ((i == 0) ? 7'd2 : 7'd0) || got_mag[i] !== ((i == 0) ? 7'd4 : 7'd1)) begin
                fails++; $display("FAIL offset_msg%0d: mag_off2=%0d mag_off0=%0d expected %0d/%0d",
                                  i, got_mag2[i], got_mag[i], (i == 0) ? 2 : 0, (i == 0) ? 4 : 1);
            end
        end
        $display("[TB] test_offset done");
    endtask

    task automatic test_stall();
        send(7'd5, 7'd6, 5'd7, 1'b0, 24'h000001, 1'b0);
        collect(1);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL stall_count: got %0d msgs expected %0d", n_got, DEG);
        end
        tests++;
        if (stall_bad != 0) begin
            fails++; $display("FAIL stall_hold: %0d output changes during stalls expected 0", stall_bad);
        end
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_idx[i] !== 5'(i) || got_sign[i] !== (i == 0) ||
                got_mag[i] !== ((i == 7) ? 7'd6 : 7'd5) || got_last[i] !== (i == DEG - 1)) begin
                fails++; $display("FAIL stall_msg%0d: idx=%0d sign=%0b mag=%0d last=%0b expected idx=%0d sign=%0b mag=%0d",
                                  i, got_idx[i], got_sign[i], got_mag[i], got_last[i], i, i == 0, (i == 7) ? 6 : 5);
            end
        end
        $display("[TB] test_stall done: %0d cycles", cycles);
    endtask

    task automatic test_no_match_equal();
        send(7'd8, 7'd12, 5'd31, 1'b0, 24'h000000, 1'b0);
        collect(0);
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_mag[i] !== 7'd8) begin
                fails++; $display("FAIL nomatch_msg%0d: mag=%0d expected 8", i, got_mag[i]);
            end
        end
        send(7'd6, 7'd6, 5'd2, 1'b1, 24'h00000F, 1'b0);
        collect(0);
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_mag[i] !== 7'd6 || got_sign[i] !== (i >= 4)) begin
                fails++; $display("FAIL equal_msg%0d: mag=%0d sign=%0b expected 6/%0b", i, got_mag[i], got_sign[i], i >= 4);
            end
        end
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL equal_count: got %0d msgs expected %0d", n_got, DEG);
        end
        $display("[TB] test_no_match_equal done");
    endtask

    task automatic test_reset_mid();
        send(7'd10, 7'd20, 5'd3, 1'b1, 24'hFFFFFF, 1'b0);
        msg_ready = 1'b1;
        repeat (10) tick();
        tests++;
        if (msg_valid !== 1'b1 || msg_idx !== 5'd10) begin
            fails++; $display("FAIL rstmid_progress: valid=%0b idx=%0d expected 1/10", msg_valid, msg_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (msg_valid !== 1'b0 || cmp_ready !== 1'b1 || msg_idx !== 5'd0 || msg_mag !== 7'd0) begin
            fails++; $display("FAIL rstmid_abort: valid=%0b cmp_ready=%0b idx=%0d mag=%0d expected 0/1/0/0",
                              msg_valid, cmp_ready, msg_idx, msg_mag);
        end
        // reset wins over a simultaneous record handshake
        cmp_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp_valid = 1'b0;
        tests++;
        if (msg_valid !== 1'b0 || cmp_ready !== 1'b1) begin
            fails++; $display("FAIL rst_priority: valid=%0b cmp_ready=%0b expected 0/1", msg_valid, cmp_ready);
        end
        send(7'd2, 7'd7, 5'd1, 1'b0, 24'h000000, 1'b0);
        collect(0);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL rstmid_count: got %0d msgs expected %0d", n_got, DEG);
        end
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_idx[i] !== 5'(i) || got_mag[i] !== ((i == 1) ? 7'd7 : 7'd2) || got_sign[i] !== 1'b0) begin
                fails++; $display("FAIL rstmid_msg%0d: idx=%0d mag=%0d sign=%0b expected idx=%0d mag=%0d sign=0",
                                  i, got_idx[i], got_mag[i], got_sign[i], i, (i == 1) ? 7 : 2);
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        send(7'd4, 7'd11, 5'd23, 1'b1, 24'h800000, 1'b1);
        // record B presented while A is still being emitted
        min_v     = 7'd6;
        submin_v  = 7'd1;
        min_idx   = 5'd0;
        sign_prod = 1'b0;
        sign_vec  = 24'h000000;
        collect(0);
        tests++;
        if (timed_out || cycles != DEG) begin
            fails++; $display("FAIL b2b_a_count: got %0d msgs in %0d cycles expected %0d", n_got, cycles, DEG);
        end
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_mag[i] !== ((i == 23) ? 7'd11 : 7'd4) || got_sign[i] !== (i != 23)) begin
                fails++; $display("FAIL b2b_a_msg%0d: mag=%0d sign=%0b expected %0d/%0b",
                                  i, got_mag[i], got_sign[i], (i == 23) ? 11 : 4, i != 23);
            end
        end
        // one idle bubble, then B is taken
        tests++;
        if (cmp_ready !== 1'b1 || msg_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_bubble: cmp_ready=%0b valid=%0b expected 1/0", cmp_ready, msg_valid);
        end
        tick();
        cmp_valid = 1'b0;
        tests++;
        if (msg_valid !== 1'b1 || msg_idx !== 5'd0 || msg_mag !== 7'd1 || cmp_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_b_start: valid=%0b idx=%0d mag=%0d cmp_ready=%0b expected 1/0/1/0",
                              msg_valid, msg_idx, msg_mag, cmp_ready);
        end
        collect(0);
        for (int i = 0; i < n_got; i++) begin
            tests++;
            if (got_mag[i] !== ((i == 0) ? 7'd1 : 7'd6) || got_sign[i] !== 1'b0) begin
                fails++; $display("FAIL b2b_b_msg%0d: mag=%0d sign=%0b expected %0d/0",
                                  i, got_mag[i], got_sign[i], (i == 0) ? 1 : 6);
            end
        end
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL b2b_b_count: got %0d msgs expected %0d", n_got, DEG);
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        rst       = 1'b1;
        cmp_valid = 1'b0;
        min_v     = '0;
        submin_v  = '0;
        min_idx   = '0;
        sign_prod = 1'b0;
        sign_vec  = '0;
        msg_ready = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_offset();
        test_stall();
        test_no_match_equal();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
